mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_if.sv | 33 +++
 rtl/mc_controller.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mc_controller_if.sv
// Control-unit bundle: opcode/flags/memory-ready in, datapath controls and debug state out.
// Full handshake is a single MemReady stall signal; the controller drives no ready back.
interface mc_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             AdrSrc;
  logic             IRWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUOp;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstRet;
  logic             Illegal;

  modport master (
    output op, Zero, MemReady,
    input  PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite,
    input  ALUSrcA, ALUSrcB, ResultSrc, ALUOp, State, InstRet, Illegal
  );

  modport slave (
    input  op, Zero, MemReady,
    output PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite,
    output ALUSrcA, ALUSrcB, ResultSrc, ALUOp, State, InstRet, Illegal
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM; beq 3 cycles, alu/sw/jal 4, lw 5; MemReady=0 stalls FETCH/MEMREAD/MEMWRITE.
// MC_ILLEGAL_TRAP_EN: unknown opcodes lock in TRAP with sticky Illegal; otherwise they retire as NOPs.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          reset,
  mc_controller_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  typedef struct packed {
    logic       adrsrc;
    logic       regwrite;
    logic       memwrite;
    logic       pcupd;
    logic       branch;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] aluop;
  } ctl_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t           state, nxt;
  ctl_t             ctl;
  logic             retire;
  logic [CNT_W-1:0] instret;

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.pcupd = 1'b1; end
      DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      MEMREAD:  c.adrsrc = 1'b1;
      MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
      MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      EXECUTER: begin c.alusrca = 2'b10; c.aluop = 2'b10; end
      EXECUTEI: begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
      ALUWB:    c.regwrite = 1'b1;
      BEQ:      begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
      JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupd = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // retire marks the edge that completes an instruction (jal counts on leaving ALUWB)
  always_comb begin
    nxt    = state;
    retire = 1'b0;
    case (state)
      FETCH:    nxt = bus.MemReady ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECUTER;
          OP_I:         nxt = EXECUTEI;
          OP_BEQ:       nxt = BEQ;
          OP_JAL:       nxt = JAL;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            nxt = TRAP;
`else
            nxt    = FETCH;
            retire = 1'b1;
`endif
          end
        endcase
      end
      MEMADR:   nxt = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = bus.MemReady ? MEMWB : MEMREAD;
      MEMWB:    begin nxt = FETCH; retire = 1'b1; end
      MEMWRITE: begin nxt = bus.MemReady ? FETCH : MEMWRITE; retire = bus.MemReady; end
      EXECUTER, EXECUTEI: nxt = ALUWB;
      ALUWB:    begin nxt = FETCH; retire = 1'b1; end
      BEQ:      begin nxt = FETCH; retire = 1'b1; end
      JAL:      nxt = ALUWB;
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal;
`endif

  // Controls are registered alongside the state so they change only with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      ctl     <= decode(FETCH);
      instret <= '0;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else begin
      state <= nxt;
      ctl   <= decode(nxt);
      if (retire) instret <= instret + CNT_W'(1);
`ifdef MC_ILLEGAL_TRAP_EN
      if (nxt == TRAP) illegal <= 1'b1;
`endif
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.Illegal = illegal;
`else
  assign bus.Illegal = 1'b0;
`endif

  // FETCH only writes IR/PC once the instruction word has actually arrived
  assign bus.IRWrite   = (state == FETCH) & bus.MemReady;
  assign bus.PCWrite   = (ctl.pcupd & ((state != FETCH) | bus.MemReady)) | (ctl.branch & bus.Zero);
  assign bus.AdrSrc    = ctl.adrsrc;
  assign bus.RegWrite  = ctl.regwrite;
  assign bus.MemWrite  = ctl.memwrite;
  assign bus.ALUSrcA   = ctl.alusrca;
  assign bus.ALUSrcB   = ctl.alusrcb;
  assign bus.ResultSrc = ctl.resultsrc;
  assign bus.ALUOp     = ctl.aluop;
  assign bus.State     = state;
  assign bus.InstRet   = instret;

endmodule
